// File: rtl/frame_scanout.sv
// frame_scanout: 640x480 VGA raster and frame-buffer FIFO read-out.
// Optional SCANOUT_UNDERFLOW_EN adds sticky underflow flag and saturating count.
module frame_scanout #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int REAL_COLOR_SIZE = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                rd_word_1,
    input  logic [15:0]                rd_word_2,
    input  logic                       rd_empty,
    output logic                       rd_req,
    output logic                       fifo_load,
    output logic [9:0]                 pix_x,
    output logic [9:0]                 pix_y,
    output logic [REAL_COLOR_SIZE-1:0] vga_r,
    output logic [REAL_COLOR_SIZE-1:0] vga_g,
    output logic [REAL_COLOR_SIZE-1:0] vga_b,
    output logic                       vga_hsync_n,
    output logic                       vga_vsync_n,
    output logic                       vga_blank_n,
    output logic [15:0]                frame_count
`ifdef SCANOUT_UNDERFLOW_EN
    ,
    output logic                       underflow,
    output logic [15:0]                underflow_count
`endif
);
    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] HL  = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0] VL  = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] VP  = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 2);

    logic [9:0] h_cnt, v_cnt;
    logic       h_end, v_end, active, hs_raw, vs_raw, hs_d, vs_d, drop, unused_bits;

    always_comb begin
        h_end  = h_cnt == HL;
        v_end  = v_cnt == VL;
        active = h_cnt < HA && v_cnt < VA;
        pix_x  = h_cnt < HA ? h_cnt : HA;
        pix_y  = v_cnt < VA ? v_cnt : VA;
        hs_raw = !(h_cnt >= HS0 && h_cnt < HS1);
        vs_raw = !(v_cnt >= VS0 && v_cnt < VS1);
    end

`ifdef SCANOUT_UNDERFLOW_EN
    assign drop        = rd_empty;
    assign unused_bits = rd_word_1[15] ^ rd_word_2[15];
`else
    assign drop        = 1'b0;
    assign unused_bits = ^{rd_word_1[15], rd_word_2[15], rd_empty};
`endif

    // rd_req lags the counters by one cycle; syncs get two stages so they line up with colour.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            rd_req      <= 1'b0;
            fifo_load   <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            vga_hsync_n <= 1'b1;
            vga_vsync_n <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_count <= '0;
        end else begin
            h_cnt       <= h_end ? '0 : h_cnt + 10'd1;
            if (h_end)
                v_cnt   <= v_end ? '0 : v_cnt + 10'd1;
            rd_req      <= active;
            fifo_load   <= h_end && v_cnt == VP;
            {vga_r, vga_g, vga_b} <= (rd_req && !drop) ?
                {rd_word_1[9:0], rd_word_1[14:10], rd_word_2[14:10], rd_word_2[9:0]} : '0;
            hs_d        <= hs_raw;
            vs_d        <= vs_raw;
            vga_hsync_n <= hs_d;
            vga_vsync_n <= vs_d;
            vga_blank_n <= rd_req;
            if (h_end && v_end)
                frame_count <= frame_count + 16'd1;
        end
    end

`ifdef SCANOUT_UNDERFLOW_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow       <= 1'b0;
            underflow_count <= '0;
        end else if (rd_req && rd_empty) begin
            underflow       <= 1'b1;
            underflow_count <= underflow_count == 16'hFFFF ? underflow_count : underflow_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: checks a full-size instance (line timing, unpack) and a shrunken
// raster instance (frame-level timing, fifo_load, frame_count, mid-frame reset).
module tb_frame_scanout;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] rd_word_1 = '0, rd_word_2 = '0;
    logic        rd_empty = 1'b0;

    logic        b_rd, b_fl, b_hs, b_vs, b_bl, s_rd, s_fl, s_hs, s_vs, s_bl;
    logic [9:0]  b_px, b_py, s_px, s_py, b_r, b_g, b_b, s_r, s_g, s_b;
    logic [15:0] b_fc, s_fc;
`ifdef SCANOUT_UNDERFLOW_EN
    logic        b_uf, s_uf;
    logic [15:0] b_ufc, s_ufc;
`endif

    always #5 clk = ~clk;

    frame_scanout dut (
        .clk(clk), .reset(reset), .rd_word_1(rd_word_1), .rd_word_2(rd_word_2),
        .rd_empty(rd_empty), .rd_req(b_rd), .fifo_load(b_fl), .pix_x(b_px), .pix_y(b_py),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .vga_hsync_n(b_hs), .vga_vsync_n(b_vs),
        .vga_blank_n(b_bl), .frame_count(b_fc)
`ifdef SCANOUT_UNDERFLOW_EN
        , .underflow(b_uf), .underflow_count(b_ufc)
`endif
    );

    // 15 x 8 raster: hsync low h in [10,13), vsync low v in [5,7), 120 cycles per frame
    frame_scanout #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .clk(clk), .reset(reset), .rd_word_1(rd_word_1), .rd_word_2(rd_word_2),
        .rd_empty(rd_empty), .rd_req(s_rd), .fifo_load(s_fl), .pix_x(s_px), .pix_y(s_py),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hsync_n(s_hs), .vga_vsync_n(s_vs),
        .vga_blank_n(s_bl), .frame_count(s_fc)
`ifdef SCANOUT_UNDERFLOW_EN
        , .underflow(s_uf), .underflow_count(s_ufc)
`endif
    );

    typedef struct {
        int   k;
        logic rd, bl, hs, vs, fl;
        int   px, py, fc;
    } vec_t;

    localparam int NV = 28;
    vec_t tv[NV];
    int   nerr = 0, nchk = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        int vi, rd_a, rd_b, b_rdn, hs_low, hs_first;
        logic [9:0] er, eg, eb;
        //        k    rd bl hs vs fl px py fc
        tv[0]  = '{0,   0, 0, 1, 1, 0, 0, 0, 0};
        tv[1]  = '{1,   1, 0, 1, 1, 0, 1, 0, 0};
        tv[2]  = '{2,   1, 1, 1, 1, 0, 2, 0, 0};
        tv[3]  = '{8,   1, 1, 1, 1, 0, 8, 0, 0};
        tv[4]  = '{9,   0, 1, 1, 1, 0, 8, 0, 0};
        tv[5]  = '{10,  0, 0, 1, 1, 0, 8, 0, 0};
        tv[6]  = '{11,  0, 0, 1, 1, 0, 8, 0, 0};
        tv[7]  = '{12,  0, 0, 0, 1, 0, 8, 0, 0};
        tv[8]  = '{14,  0, 0, 0, 1, 0, 8, 0, 0};
        tv[9]  = '{15,  0, 0, 1, 1, 0, 0, 1, 0};
        tv[10] = '{16,  1, 0, 1, 1, 0, 1, 1, 0};
        tv[11] = '{61,  0, 0, 1, 1, 0, 1, 4, 0};
        tv[12] = '{68,  0, 0, 1, 1, 0, 8, 4, 0};
        tv[13] = '{76,  0, 0, 1, 1, 0, 1, 4, 0};
        tv[14] = '{77,  0, 0, 1, 0, 0, 2, 4, 0};
        tv[15] = '{104, 0, 0, 0, 0, 0, 8, 4, 0};
        tv[16] = '{105, 0, 0, 1, 0, 1, 0, 4, 0};
        tv[17] = '{106, 0, 0, 1, 0, 0, 1, 4, 0};
        tv[18] = '{107, 0, 0, 1, 1, 0, 2, 4, 0};
        tv[19] = '{119, 0, 0, 0, 1, 0, 8, 4, 0};
        tv[20] = '{120, 0, 0, 1, 1, 0, 0, 0, 1};
        tv[21] = '{121, 1, 0, 1, 1, 0, 1, 0, 1};
        tv[22] = '{224, 0, 0, 0, 0, 0, 8, 4, 1};
        tv[23] = '{225, 0, 0, 1, 0, 1, 0, 4, 1};
        tv[24] = '{226, 0, 0, 1, 0, 0, 1, 4, 1};
        tv[25] = '{240, 0, 0, 1, 1, 0, 0, 0, 2};
        tv[26] = '{241, 1, 0, 1, 1, 0, 1, 0, 2};
        tv[27] = '{242, 1, 1, 1, 1, 0, 2, 0, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vi = 0; rd_a = 0; rd_b = 0; b_rdn = 0; hs_low = 0; hs_first = -1;
        for (int k = 0; k <= 873; k++) begin
            if (vi < NV && tv[vi].k == k) begin
                chk($sformatf("k%0d rd_req", k), 32'(s_rd), 32'(tv[vi].rd));
                chk($sformatf("k%0d blank_n", k), 32'(s_bl), 32'(tv[vi].bl));
                chk($sformatf("k%0d hsync_n", k), 32'(s_hs), 32'(tv[vi].hs));
                chk($sformatf("k%0d vsync_n", k), 32'(s_vs), 32'(tv[vi].vs));
                chk($sformatf("k%0d fifo_load", k), 32'(s_fl), 32'(tv[vi].fl));
                chk($sformatf("k%0d pix_x", k), 32'(s_px), 32'(tv[vi].px));
                chk($sformatf("k%0d pix_y", k), 32'(s_py), 32'(tv[vi].py));
                chk($sformatf("k%0d frame_count", k), 32'(s_fc), 32'(tv[vi].fc));
                vi++;
            end
            if (k < 120) rd_a += int'(s_rd);
            else if (k < 240) rd_b += int'(s_rd);
            if (k >= 1 && k <= 800) b_rdn += int'(b_rd);
            if (k <= 820 && !b_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
            end
            // colour pipeline and underflow corner cases
            er = 10'h2AA; eg = 10'h155; eb = 10'h155;
`ifdef SCANOUT_UNDERFLOW_EN
            if (k >= 4 && k <= 6) begin er = '0; eg = '0; eb = '0; end
`endif
            if (k == 0) chk("reset colour", {2'b0, s_r, s_g, s_b}, 32'h0);
            if (k == 2) begin
                chk("px00 big r", 32'(b_r), 32'h155);
                chk("px00 big g", 32'(b_g), 32'h3E0);
                chk("px00 big b", 32'(b_b), 32'h3FF);
                chk("px00 big blank_n", 32'(b_bl), 32'h1);
                chk("px00 small rgb", {2'b0, s_r, s_g, s_b}, {2'b0, 10'h155, 10'h3E0, 10'h3FF});
`ifdef SCANOUT_UNDERFLOW_EN
                chk("underflow before", 32'(s_uf), 32'h0);
`endif
            end
            if (k >= 3 && k <= 7)
                chk($sformatf("k%0d small rgb", k), {2'b0, s_r, s_g, s_b}, {2'b0, er, eg, eb});
            if (k == 10) begin
                chk("blank colour small", {2'b0, s_r, s_g, s_b}, 32'h0);
                chk("active colour big r", 32'(b_r), 32'h2AA);
            end
            if (k == 700) chk("big pix_x hblank", {b_py, b_px}, {10'd0, 10'd640});
            if (k == 800) chk("big line wrap pix", {b_py, b_px}, {10'd1, 10'd0});
            if (k == 873) chk("pre-reset small pix", {s_py, s_px, 1'b0, s_rd}, {10'd2, 10'd3, 2'b01});
            rd_word_1 = k == 1 ? 16'h7D55 : 16'hAAAA;
            rd_word_2 = k == 1 ? 16'h03FF : 16'h5555;
            rd_empty  = (k >= 3 && k <= 5) || k == 12;
            if (k < 873) @(negedge clk);
        end
        chk("reads frame 0", 32'(rd_a), 32'd32);
        chk("reads frame 1", 32'(rd_b), 32'd32);
        chk("big reads line 0", 32'(b_rdn), 32'd640);
        chk("big hsync width", 32'(hs_low), 32'd96);
        chk("big hsync start", 32'(hs_first), 32'd658);
`ifdef SCANOUT_UNDERFLOW_EN
        chk("small underflow", 32'(s_uf), 32'h1);
        chk("small underflow_count", 32'(s_ufc), 32'd3);
        chk("big underflow_count", 32'(b_ufc), 32'd4);
`endif
        // single-cycle reset at small-raster pixel (3,2)
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset rd_req", 32'(s_rd), 32'h0);
        chk("mid reset colour", {2'b0, s_r, s_g, s_b}, 32'h0);
        chk("mid reset big colour", {2'b0, b_r, b_g, b_b}, 32'h0);
        chk("mid reset syncs", {s_hs, s_vs, s_bl, s_fl}, 4'b1100);
        chk("mid reset pix", {s_py, s_px}, 20'h0);
        chk("mid reset frame_count", 32'(s_fc), 32'h0);
`ifdef SCANOUT_UNDERFLOW_EN
        chk("mid reset underflow", {s_uf, s_ufc}, 17'h0);
`endif
        @(negedge clk);
        chk("post reset rd_req", {s_rd, s_bl}, 2'b10);
        chk("post reset pix_x", 32'(s_px), 32'd1);
        @(negedge clk);
        chk("post reset blank_n", {s_rd, s_bl}, 2'b11);
        chk("post reset rgb", {2'b0, s_r, s_g, s_b}, {2'b0, 10'h2AA, 10'h155, 10'h155});
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
